// File: rtl/oam_eval_gen.sv
// oam_eval_gen: per-scanline sprite evaluation.
// Clears secondary OAM, scans primary OAM for sprites whose Y range covers
// LINE_Y, copies up to LINE_SPR hits into secondary OAM, then keeps probing
// the remaining entries for an exact overflow.
//
// Ports:
//   PCLK, RES            clock, async active-high reset
//   EV_START, LINE_Y,    start pulse, line and sprite height
//   TALL                 (line and height latched on EV_START)
//   OV_CLR               clears the sticky overflow flag
//   OAM_ADDR/OAM_DATA    primary OAM read port (data one cycle after address)
//   SOAM_ADDR/DATA/WE    secondary OAM write port
//   SPR_CNT, SPR0_IN,    sprites copied, entry 0 copied, overflow
//   SPR_OV
//   BUSY, DONE           evaluation active, one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for EV_START
// CLEAR  | fill secondary OAM with 0xFF
// RD_Y   | address Y byte of entry n
// CMP_Y  | range test; on hit write Y byte to slot s
// RD_B   | address byte k of entry n
// WR_B   | copy byte k to slot s
// OV_RD  | address Y byte of entry n (slots full)
// OV_CMP | range test only; hit sets SPR_OV
// FIN    | DONE pulse
module oam_eval_gen #(
  parameter int  NUM_SPR  = 64,
  parameter int  LINE_SPR = 8,
  localparam int AW       = $clog2(NUM_SPR * 4),
  localparam int SW       = $clog2(LINE_SPR * 4),
  localparam int CW       = $clog2(LINE_SPR) + 1
) (
  input  logic          PCLK,
  input  logic          RES,
  input  logic          EV_START,
  input  logic [7:0]    LINE_Y,
  input  logic          TALL,
  input  logic          OV_CLR,
  output logic [AW-1:0] OAM_ADDR,
  input  logic [7:0]    OAM_DATA,
  output logic [SW-1:0] SOAM_ADDR,
  output logic [7:0]    SOAM_DATA,
  output logic          SOAM_WE,
  output logic [CW-1:0] SPR_CNT,
  output logic          SPR0_IN,
  output logic          SPR_OV,
  output logic          BUSY,
  output logic          DONE
);

  localparam int NW = $clog2(NUM_SPR);

  typedef enum logic [3:0] {
    IDLE, CLEAR, RD_Y, CMP_Y, RD_B, WR_B, OV_RD, OV_CMP, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [1:0]    k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] clr_q, clr_d;
  logic [7:0]    ly_q, ly_d;
  logic          tall_q, tall_d;
  logic          spr0_q, spr0_d;
  logic          ov_q, ov_d;
  logic [AW-1:0] oam_addr_q;

  logic [8:0]    diff;
  logic          hit;
  logic          n_last;
  logic          slot_full;
  logic [SW-1:0] slot_base;

  // 9-bit subtract: a Y above the line gives a borrow and never hits.
  assign diff      = {1'b0, ly_q} - {1'b0, OAM_DATA};
  assign hit       = ~diff[8] && (diff[7:0] < (tall_q ? 8'd16 : 8'd8));
  assign n_last    = (n_q == NW'(NUM_SPR - 1));
  assign slot_full = (cnt_q == CW'(LINE_SPR - 1));
  assign slot_base = SW'({cnt_q, 2'b00});

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    ly_d      = ly_q;
    tall_d    = tall_q;
    spr0_d    = spr0_q;
    ov_d      = ov_q;
    OAM_ADDR  = oam_addr_q;
    SOAM_ADDR = '0;
    SOAM_DATA = 8'hFF;
    SOAM_WE   = 1'b0;
    DONE      = 1'b0;

    if (OV_CLR) ov_d = 1'b0;

    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        SOAM_WE   = 1'b1;
        SOAM_ADDR = clr_q;
        clr_d     = clr_q + SW'(1);
        if (clr_q == SW'(4 * LINE_SPR - 1)) state_d = RD_Y;
      end
      RD_Y: begin
        OAM_ADDR = {n_q, 2'b00};
        state_d  = CMP_Y;
      end
      CMP_Y: begin
        if (hit) begin
          SOAM_WE   = 1'b1;
          SOAM_ADDR = slot_base;
          SOAM_DATA = OAM_DATA;
          k_d       = 2'd1;
          state_d   = RD_B;
          if (n_q == '0) spr0_d = 1'b1;
        end else if (n_last) begin
          state_d = FIN;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = RD_Y;
        end
      end
      RD_B: begin
        OAM_ADDR = {n_q, k_q};
        state_d  = WR_B;
      end
      WR_B: begin
        SOAM_WE   = 1'b1;
        SOAM_ADDR = slot_base | SW'(k_q);
        SOAM_DATA = OAM_DATA;
        if (k_q != 2'd3) begin
          k_d     = k_q + 2'd1;
          state_d = RD_B;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (n_last) begin
            state_d = FIN;
          end else begin
            n_d     = n_q + NW'(1);
            state_d = slot_full ? OV_RD : RD_Y;
          end
        end
      end
      OV_RD: begin
        OAM_ADDR = {n_q, 2'b00};
        state_d  = OV_CMP;
      end
      OV_CMP: begin
        if (hit) begin
          ov_d    = 1'b1;
          state_d = FIN;
        end else if (n_last) begin
          state_d = FIN;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = OV_RD;
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start pulse restarts from any state; the overflow flag survives.
    if (EV_START) begin
      state_d = CLEAR;
      ly_d    = LINE_Y;
      tall_d  = TALL;
      cnt_d   = '0;
      spr0_d  = 1'b0;
      n_d     = '0;
      k_d     = '0;
      clr_d   = '0;
    end
  end

  always_ff @(posedge PCLK or posedge RES) begin
    if (RES) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      clr_q      <= '0;
      ly_q       <= '0;
      tall_q     <= 1'b0;
      spr0_q     <= 1'b0;
      ov_q       <= 1'b0;
      oam_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      clr_q      <= clr_d;
      ly_q       <= ly_d;
      tall_q     <= tall_d;
      spr0_q     <= spr0_d;
      ov_q       <= ov_d;
      oam_addr_q <= OAM_ADDR;
    end
  end

  assign SPR_CNT = cnt_q;
  assign SPR0_IN = spr0_q;
  assign SPR_OV  = ov_q;
  assign BUSY    = (state_q != IDLE);

endmodule
